fir_host_seq: RTL and testbench

Host-side sequencer for the single-MAC FIR filter controller. It takes a frame of input samples over a valid/ready stream and writes them into the filter's sample memory. It then clears and starts the filter through ctrl[1:0] and collects each filter result when the controller strobes its output-memory write. Results are returned on a valid/ready output stream through a small FIFO.

---
 rtl/fir_host_seq_pkg.sv | 18 +
 rtl/fir_out_fifo.sv | 67 ++++++
 rtl/fir_host_seq.sv | 179 +++++++++++++++++
 tb/tb_fir_host_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_host_seq_pkg.sv
// Shared types and constants for the FIR host-side sequencer.
package fir_host_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD,
        ST_START,
        ST_WAITB,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam logic [1:0] CTRL_START = 2'b01;
    localparam logic [1:0] CTRL_CLR   = 2'b10;
    localparam int         WAITB_TMO  = 15;

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous first-word-fall-through FIFO holding filter results.
module fir_out_fifo #(
    parameter int DW     = 16,
    parameter int FIFO_D = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);
    localparam int           PW       = $clog2(FIFO_D);
    localparam logic [PW:0]  CNT_FULL = (PW+1)'(FIFO_D);

    logic [DW-1:0] mem_q [FIFO_D];
    logic [DW-1:0] mem_d [FIFO_D];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && !empty;
        // a pop in the same cycle frees the slot for a push into a full FIFO
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_D; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fir_host_seq.sv
// Host sequencer: loads a sample frame, kicks the FIR controller, and
// streams collected results out through a small FIFO.
//   state    | meaning
//   IDLE     | waiting for go
//   CLR      | one-cycle clear pulse to the filter
//   LOAD     | accepting samples into sample memory
//   START    | one-cycle start pulse; last sample write lands here
//   WAITB    | waiting for the filter to report busy (timed)
//   RUN      | collecting results on rw2
//   DRAIN    | waiting for the output FIFO to empty
module fir_host_seq
    import fir_host_seq_pkg::*;
#(
    parameter int DW     = 16,
    parameter int AW     = 6,
    parameter int FRAME  = 32,
    parameter int FIFO_D = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    ctrl,
    input  logic          bsy,
    input  logic          rw2,
    input  logic [DW-1:0] douta,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic          frame_done,
    output logic          ovf
);
    localparam int           TMO_W     = $clog2(WAITB_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(WAITB_TMO - 1);
    localparam logic [AW:0]  FRAME_CNT = (AW+1)'(FRAME);
    localparam logic [AW:0]  LAST_IDX  = (AW+1)'(FRAME - 1);

    state_e            state_q, state_d;
    logic [AW:0]       ld_cnt_q, ld_cnt_d;
    logic [AW:0]       res_cnt_q, res_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              frame_done_q, frame_done_d;
    logic              ovf_q, ovf_d;

    logic              s_hs, push_req, fifo_pop, fifo_full, fifo_empty;

    assign s_ready    = (state_q == ST_LOAD);
    assign s_hs       = s_ready && s_valid;
    assign push_req   = (state_q == ST_RUN) && rw2;
    assign m_valid    = !fifo_empty;
    assign fifo_pop   = m_valid && m_ready;
    assign ctrl       = (state_q == ST_CLR)   ? CTRL_CLR   :
                        (state_q == ST_START) ? CTRL_START : 2'b00;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign frame_done = frame_done_q;
    assign ovf        = ovf_q;

    fir_out_fifo #(
        .DW     (DW),
        .FIFO_D (FIFO_D)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (douta),
        .pop       (fifo_pop),
        .head      (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        res_cnt_d    = res_cnt_q;
        tmo_d        = tmo_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        frame_done_d = 1'b0;
        ovf_d        = ovf_q;

        if (s_hs) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ld_cnt_q[AW-1:0];
            mem_wdata_d = s_data;
            ld_cnt_d    = ld_cnt_q + 1'b1;
        end
        if (push_req) begin
            res_cnt_d = res_cnt_q + 1'b1;
            if (fifo_full && !fifo_pop) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d   = ST_CLR;
                    ovf_d     = 1'b0;
                    ld_cnt_d  = '0;
                    res_cnt_d = '0;
                end
            end
            ST_CLR: state_d = ST_LOAD;
            ST_LOAD: begin
                if (s_hs && (ld_cnt_q == LAST_IDX)) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAITB;
                tmo_d   = TMO_LOAD;
            end
            ST_WAITB: begin
                if (bsy) begin
                    state_d = ST_RUN;
                end else if (tmo_q == '0) begin
                    // filter never acknowledged start: abort the frame
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    ovf_d        = 1'b1;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (!bsy) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    if (res_cnt_q != FRAME_CNT) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ld_cnt_q     <= '0;
            res_cnt_q    <= '0;
            tmo_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            res_cnt_q    <= res_cnt_d;
            tmo_q        <= tmo_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fir_host_seq.sv
// Directed/randomized bench for fir_host_seq with a queue-based reference model.
module tb_fir_host_seq;
    localparam int DW     = 16;
    localparam int AW     = 6;
    localparam int FRAME  = 32;
    localparam int FIFO_D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          go = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    ctrl;
    logic          bsy = 1'b0;
    logic          rw2 = 1'b0;
    logic [DW-1:0] douta = '0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b1;
    logic          frame_done;
    logic          ovf;

    fir_host_seq #(.DW(DW), .AW(AW), .FRAME(FRAME), .FIFO_D(FIFO_D)) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .ctrl       (ctrl),
        .bsy        (bsy),
        .rw2        (rw2),
        .douta      (douta),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .frame_done (frame_done),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // observation log, written only here
    int wr_addr_log[$];
    int wr_data_log[$];
    int out_log[$];
    int clr_seen   = 0;
    int start_seen = 0;
    int fd_seen    = 0;
    int both_seen  = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (mem_we) begin
                wr_addr_log.push_back(int'(mem_addr));
                wr_data_log.push_back(int'(mem_wdata));
            end
            if (ctrl == 2'b10) clr_seen++;
            if (ctrl == 2'b01) start_seen++;
            if (ctrl == 2'b11) both_seen++;
            if (m_valid && m_ready) out_log.push_back(int'(m_data));
            if (frame_done) fd_seen++;
        end
    end

    // reference model state
    int exp_smp[FRAME];
    int exp_out[$];
    bit exp_ovf;
    int occ;
    int b_wr, b_out, b_clr, b_start, b_fd, b_both;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {s_ready, mem_we, ctrl, m_valid, frame_done, ovf}, '0);
        chk({tag, "_addr"}, 64'(mem_addr), '0);
        chk({tag, "_wdata"}, 64'(mem_wdata), '0);
        chk({tag, "_mdata"}, 64'(m_data), '0);
    endtask

    task automatic start_frame();
        b_wr = wr_addr_log.size(); b_out = out_log.size();
        b_clr = clr_seen; b_start = start_seen; b_fd = fd_seen; b_both = both_seen;
        exp_out.delete();
        exp_ovf = 1'b0;
        occ = 0;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic load_samples(input bit rnd);
        int sent = 0;
        int budget = 0;
        for (int i = 0; i < FRAME; i++) exp_smp[i] = rnd ? int'($urandom_range(0, 65535)) : i + 1;
        while (sent < FRAME && budget < 2000) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = DW'(exp_smp[sent]);
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            budget++;
            tick();
        end
        s_valid = 1'b0;
        chk("load_handshakes", 64'(sent), 64'(FRAME));
    endtask

    task automatic wait_start();
        bit ok = 1'b0;
        for (int b = 0; b < 100 && !ok; b++) begin
            @(negedge clk);
            if (ctrl == 2'b01) ok = 1'b1;
        end
        chk("start_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_fd(input int limit);
        bit ok = 1'b0;
        for (int b = 0; b < limit && !ok; b++) begin
            @(negedge clk);
            if (frame_done) ok = 1'b1;
        end
        chk("frame_done_seen", 64'(ok), 64'd1);
    endtask

    // filter model: bsy two cycles after start, strobes every 9 cycles
    task automatic strobes(input int n_res, input bit ready_run, input bit rnd, input bit chk_ovf);
        tick();
        tick();
        bsy = 1'b1;
        m_ready = ready_run;
        for (int n = 0; n < n_res; n++) begin
            repeat (8) tick();
            rw2   = 1'b1;
            douta = rnd ? DW'($urandom) : DW'(16'h1000 + n);
            if (ready_run) occ = 0;
            if (occ < FIFO_D) begin
                exp_out.push_back(int'(douta));
                occ++;
            end else begin
                exp_ovf = 1'b1;
            end
            tick();
            rw2 = 1'b0;
            @(negedge clk);
            if (chk_ovf) chk($sformatf("ovf_after_strobe%0d", n), 64'(ovf), 64'(exp_ovf));
        end
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nwrites"}, 64'(wr_addr_log.size() - b_wr), 64'(FRAME));
        for (int i = 0; i < FRAME && b_wr + i < wr_addr_log.size(); i++) begin
            chk($sformatf("%s_waddr%0d", tag, i), 64'(wr_addr_log[b_wr + i]), 64'(i));
            chk($sformatf("%s_wdata%0d", tag, i), 64'(wr_data_log[b_wr + i]), 64'(exp_smp[i]));
        end
        chk({tag, "_clr_pulses"}, 64'(clr_seen - b_clr), 64'd1);
        chk({tag, "_start_pulses"}, 64'(start_seen - b_start), 64'd1);
        chk({tag, "_ctrl_both"}, 64'(both_seen - b_both), 64'd0);
        chk({tag, "_fd_pulses"}, 64'(fd_seen - b_fd), 64'd1);
        chk({tag, "_nresults"}, 64'(out_log.size() - b_out), 64'(exp_out.size()));
        for (int i = 0; i < exp_out.size() && b_out + i < out_log.size(); i++)
            chk($sformatf("%s_res%0d", tag, i), 64'(out_log[b_out + i]), 64'(exp_out[i]));
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        chk({tag, "_mvalid"}, 64'(m_valid), 64'd0);
    endtask

    task automatic full_frame(input string tag, input bit rnd_load, input bit ready_run, input bit rnd_res);
        start_frame();
        load_samples(rnd_load);
        wait_start();
        strobes(FRAME, ready_run, rnd_res, !ready_run);
        repeat (3) tick();
        bsy = 1'b0;
        if (!ready_run) begin
            repeat (5) tick();
            chk({tag, "_held_valid"}, 64'(m_valid), 64'd1);
            chk({tag, "_held_head"}, 64'(m_data), 64'(exp_out[0]));
            chk({tag, "_no_fd_while_held"}, 64'(fd_seen - b_fd), 64'd0);
            m_ready = 1'b1;
        end
        wait_fd(300);
        repeat (3) tick();
        check_frame(tag);
    endtask

    initial begin
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        tick();

        full_frame("basic", 1'b0, 1'b1, 1'b0);
        full_frame("stall", 1'b0, 1'b0, 1'b0);
        full_frame("rndload", 1'b1, 1'b1, 1'b1);

        // bsy never rises: abort after the WAITB timeout
        begin
            int cyc = 0;
            start_frame();
            load_samples(1'b0);
            wait_start();
            do begin
                @(negedge clk);
                cyc++;
            end while (!frame_done && cyc < 100);
            chk("tmo_cycles", 64'(cyc), 64'd16);
            chk("tmo_ovf", 64'(ovf), 64'd1);
            repeat (3) tick();
            chk("tmo_fd_pulses", 64'(fd_seen - b_fd), 64'd1);
            chk("tmo_no_results", 64'(out_log.size() - b_out), 64'd0);
            chk("tmo_idle", {s_ready, ctrl, m_valid}, '0);
        end

        // asynchronous reset while results sit in the FIFO
        start_frame();
        load_samples(1'b1);
        wait_start();
        strobes(3, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("pre_reset_valid", 64'(m_valid), 64'd1);
        #2 rst = 1'b0;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        check_idle_outputs("rst_next_cycle");
        bsy = 1'b0;
        m_ready = 1'b1;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        full_frame("post_rst", 1'b0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
